lane_id_mapper: RTL and testbench

Registered, parametrised successor to the combinational one-hot lane-ID decoder in the 100GbE PCS receive alignment path. Each cycle it takes one detected alignment-marker ID in one-hot form, tagged with the physical lane it arrived on, and converts it to binary with legality checking. Per physical lane, it builds a lock-qualified table mapping physical lane to logical lane. The deskew/reorder stage consumes the table, the per-lane lock flags and the global all-locked / duplicate status.

---
 rtl/pcs_lane_pkg.sv | 24 ++
 rtl/lane_onehot_encoder.sv | 35 +++
 rtl/lane_id_mapper.sv | 168 ++++++++++++++++
 tb/tb_lane_id_mapper.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_lane_pkg.sv
// Shared lane-numbering helpers for the PCS receive alignment path.
// Holds the default lane/lock sizing and the per-lane table action encoding.
package pcs_lane_pkg;

  localparam int DEF_NB_LANES = 20;
  localparam int DEF_N_LOCK   = 4;

  typedef enum logic [1:0] {
    LANE_HOLD,
    LANE_INC,
    LANE_LOAD,
    LANE_ZERO
  } lane_act_e;

  // A single-lane build still needs a one-bit index.
  function automatic int lane_id_width(input int nb_lanes);
    return (nb_lanes > 1) ? $clog2(nb_lanes) : 1;
  endfunction

  function automatic int lock_cnt_width(input int n_lock);
    return $clog2(n_lock + 1);
  endfunction

endpackage

// File: rtl/lane_onehot_encoder.sv
// Combinational one-hot to binary lane-ID encoder with an illegal-pattern flag.
// An illegal pattern (no bits or several bits set) encodes as ID 0.
module lane_onehot_encoder
  import pcs_lane_pkg::*;
#(
  parameter int NB_LANES   = DEF_NB_LANES,
  parameter int NB_LANE_ID = lane_id_width(DEF_NB_LANES)
) (
  input  logic [NB_LANES-1:0]   i_onehot,
  output logic [NB_LANE_ID-1:0] o_id,
  output logic                  o_illegal
);

  logic                  w_seen;
  logic                  w_multi;
  logic [NB_LANE_ID-1:0] w_orId;

  // OR of the indices of all set bits is the ID whenever exactly one bit is set.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    w_orId  = '0;
    for (int i = 0; i < NB_LANES; i++) begin
      if (i_onehot[i]) begin
        w_multi = w_multi | w_seen;
        w_seen  = 1'b1;
        w_orId  = w_orId | NB_LANE_ID'(i);
      end
    end
  end

  assign o_illegal = ~w_seen | w_multi;
  assign o_id      = o_illegal ? '0 : w_orId;

endmodule

// File: rtl/lane_id_mapper.sv
// Registered lane-ID decoder building a lock-qualified physical->logical lane map.
// Define LANE_ID_DUP_CHECK_EN to build the duplicate-ID checker; otherwise o_dup_err is 0.
module lane_id_mapper
  import pcs_lane_pkg::*;
#(
  parameter int NB_LANES    = DEF_NB_LANES,
  parameter int NB_LANE_ID  = lane_id_width(NB_LANES),
  parameter int N_LOCK      = DEF_N_LOCK,
  parameter int NB_LOCK_CNT = lock_cnt_width(N_LOCK)
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_valid,
  input  logic [NB_LANES-1:0]            i_id,
  input  logic [NB_LANE_ID-1:0]          i_phy_lane,
  input  logic                           i_clear,
  output logic [NB_LANE_ID-1:0]          o_id,
  output logic                           o_id_valid,
  output logic                           o_err_onehot,
  output logic                           o_err_range,
  output logic [NB_LANES-1:0]            o_lock,
  output logic [NB_LANES*NB_LANE_ID-1:0] o_map,
  output logic                           o_all_locked,
  output logic                           o_dup_err
);

  localparam logic [NB_LOCK_CNT-1:0] LP_LOCK_CNT   = NB_LOCK_CNT'(N_LOCK);
  localparam logic [NB_LANE_ID:0]    LP_LANE_LIMIT = (NB_LANE_ID+1)'(NB_LANES);

  logic [NB_LANE_ID-1:0] w_encId;
  logic                  w_encIllegal;
  logic                  w_laneOk;
  logic                  w_tableEn;
  logic [NB_LANE_ID-1:0] w_map [NB_LANES];
  logic [NB_LANES-1:0]   w_lock;

  logic [NB_LANE_ID-1:0] r_id;
  logic                  r_idValid;
  logic                  r_errOnehot;
  logic                  r_errRange;
  logic                  r_allLocked;

  lane_onehot_encoder #(
    .NB_LANES   (NB_LANES),
    .NB_LANE_ID (NB_LANE_ID)
  ) u_encoder (
    .i_onehot  (i_id),
    .o_id      (w_encId),
    .o_illegal (w_encIllegal)
  );

  // The lane index field can encode values past the last physical lane.
  assign w_laneOk  = {1'b0, i_phy_lane} < LP_LANE_LIMIT;
  assign w_tableEn = i_valid & ~i_clear & w_laneOk;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_id        <= '0;
      r_idValid   <= 1'b0;
      r_errOnehot <= 1'b0;
      r_errRange  <= 1'b0;
    end else begin
      r_idValid   <= i_valid;
      r_errOnehot <= i_valid & w_encIllegal;
      r_errRange  <= i_valid & ~w_laneOk;
      if (i_valid) begin
        r_id <= w_encId;
      end
    end
  end

  for (genvar p = 0; p < NB_LANES; p++) begin : g_lane
    lane_act_e              w_act;
    logic [NB_LOCK_CNT-1:0] w_cntNext;
    logic [NB_LOCK_CNT-1:0] r_cnt;
    logic [NB_LANE_ID-1:0]  r_map;
    logic                   r_lock;

    // Clear outranks any table write landing in the same cycle.
    always_comb begin
      w_act = LANE_HOLD;
      if (i_clear) begin
        w_act = LANE_ZERO;
      end else if (w_tableEn && (i_phy_lane == NB_LANE_ID'(p))) begin
        if (w_encIllegal) begin
          w_act = LANE_ZERO;
        end else if (w_encId == r_map) begin
          w_act = LANE_INC;
        end else begin
          w_act = LANE_LOAD;
        end
      end
    end

    always_comb begin
      w_cntNext = r_cnt;
      case (w_act)
        LANE_INC:  w_cntNext = (r_cnt == LP_LOCK_CNT) ? r_cnt : r_cnt + NB_LOCK_CNT'(1);
        LANE_LOAD: w_cntNext = NB_LOCK_CNT'(1);
        LANE_ZERO: w_cntNext = '0;
        default:   w_cntNext = r_cnt;
      endcase
    end

    // Lock follows the next counter value so a mismatch drops it on the same edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_cnt  <= '0;
        r_map  <= '0;
        r_lock <= 1'b0;
      end else begin
        r_cnt  <= w_cntNext;
        r_lock <= (w_cntNext == LP_LOCK_CNT);
        if (w_act == LANE_LOAD) begin
          r_map <= w_encId;
        end
      end
    end

    assign w_map[p]                            = r_map;
    assign w_lock[p]                           = r_lock;
    assign o_map[p*NB_LANE_ID +: NB_LANE_ID]   = w_map[p];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_allLocked <= 1'b0;
    end else begin
      r_allLocked <= &w_lock;
    end
  end

`ifdef LANE_ID_DUP_CHECK_EN
  logic w_dup;
  logic r_dupErr;

  always_comb begin
    w_dup = 1'b0;
    for (int p = 0; p < NB_LANES; p++) begin
      for (int q = p + 1; q < NB_LANES; q++) begin
        if (w_lock[p] && w_lock[q] && (w_map[p] == w_map[q])) begin
          w_dup = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dupErr <= 1'b0;
    end else begin
      r_dupErr <= w_dup;
    end
  end

  assign o_dup_err = r_dupErr;
`else
  assign o_dup_err = 1'b0;
`endif

  assign o_id         = r_id;
  assign o_id_valid   = r_idValid;
  assign o_err_onehot = r_errOnehot;
  assign o_err_range  = r_errRange;
  assign o_lock       = w_lock;
  assign o_all_locked = r_allLocked;

endmodule

// File: tb/tb_lane_id_mapper.sv
// Directed self-checking bench for lane_id_mapper with hand-computed expectations.
// Duplicate-error expectation follows LANE_ID_DUP_CHECK_EN.
module tb_lane_id_mapper;

  localparam int NB_LANES   = 20;
  localparam int NB_LANE_ID = 5;

`ifdef LANE_ID_DUP_CHECK_EN
  localparam logic EXP_DUP = 1'b1;
`else
  localparam logic EXP_DUP = 1'b0;
`endif

  logic                           clock;
  logic                           resetN;
  logic                           valid;
  logic [NB_LANES-1:0]            id;
  logic [NB_LANE_ID-1:0]          phyLane;
  logic                           clear;
  logic [NB_LANE_ID-1:0]          outId;
  logic                           outIdValid;
  logic                           errOnehot;
  logic                           errRange;
  logic [NB_LANES-1:0]            lock;
  logic [NB_LANES*NB_LANE_ID-1:0] map;
  logic                           allLocked;
  logic                           dupErr;

  int checks = 0;
  int errors = 0;

  lane_id_mapper dut (
    .i_clock      (clock),
    .i_reset_n    (resetN),
    .i_valid      (valid),
    .i_id         (id),
    .i_phy_lane   (phyLane),
    .i_clear      (clear),
    .o_id         (outId),
    .o_id_valid   (outIdValid),
    .o_err_onehot (errOnehot),
    .o_err_range  (errRange),
    .o_lock       (lock),
    .o_map        (map),
    .o_all_locked (allLocked),
    .o_dup_err    (dupErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [NB_LANE_ID-1:0] mapLane(input int p);
    return map[p*NB_LANE_ID +: NB_LANE_ID];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [NB_LANE_ID-1:0] lane,
                               input logic [NB_LANES-1:0] idIn, input logic clr);
    valid   = v;
    phyLane = lane;
    id      = idIn;
    clear   = clr;
    @(posedge clock);
    #1;
    valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    logic [NB_LANES-1:0] permId;

    resetN  = 1'b0;
    valid   = 1'b0;
    id      = '0;
    phyLane = '0;
    clear   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_id", 64'(outId), 64'd0);
    checkOutput("rst_idvalid", 64'(outIdValid), 64'd0);
    checkOutput("rst_lock", 64'(lock), 64'd0);
    checkOutput("rst_map", 64'(|map), 64'd0);
    checkOutput("rst_alllocked", 64'(allLocked), 64'd0);
    checkOutput("rst_dup", 64'(dupErr), 64'd0);
    resetN = 1'b1;

    $display("[TB] basic decode");
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b0);
    checkOutput("dec_id", 64'(outId), 64'd10);
    checkOutput("dec_idvalid", 64'(outIdValid), 64'd1);
    checkOutput("dec_erronehot", 64'(errOnehot), 64'd0);
    checkOutput("dec_errrange", 64'(errRange), 64'd0);
    checkOutput("dec_map3", 64'(mapLane(3)), 64'd10);
    applyStimulus(1'b0, 5'd0, 20'h00000, 1'b0);
    checkOutput("idle_idvalid", 64'(outIdValid), 64'd0);

    $display("[TB] illegal ids reset lane counter");
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b0);
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b0);
    checkOutput("lane3_cnt3_lock", 64'(lock[3]), 64'd0);
    applyStimulus(1'b1, 5'd3, 20'h00000, 1'b0);
    checkOutput("zero_erronehot", 64'(errOnehot), 64'd1);
    checkOutput("zero_id", 64'(outId), 64'd0);
    checkOutput("zero_idvalid", 64'(outIdValid), 64'd1);
    applyStimulus(1'b1, 5'd3, 20'h00003, 1'b0);
    checkOutput("multi_erronehot", 64'(errOnehot), 64'd1);
    checkOutput("multi_id", 64'(outId), 64'd0);
    checkOutput("illegal_map3_kept", 64'(mapLane(3)), 64'd10);
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b0);
    checkOutput("lane3_restart_lock", 64'(lock[3]), 64'd0);
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b0);
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b0);
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b0);
    checkOutput("lane3_relock", 64'(lock[3]), 64'd1);

    $display("[TB] lane 5 lock and mismatch");
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(1'b1, 5'd5, 20'h00080, 1'b0);
      if (n == 3) checkOutput("lane5_lock_n3", 64'(lock[5]), 64'd0);
    end
    checkOutput("lane5_lock_n4", 64'(lock[5]), 64'd1);
    checkOutput("lane5_map7", 64'(mapLane(5)), 64'd7);
    applyStimulus(1'b1, 5'd5, 20'h00100, 1'b0);
    checkOutput("lane5_mismatch_lock", 64'(lock[5]), 64'd0);
    checkOutput("lane5_map8", 64'(mapLane(5)), 64'd8);

    $display("[TB] out-of-range lane");
    applyStimulus(1'b1, 5'd25, 20'h00001, 1'b0);
    checkOutput("range_err", 64'(errRange), 64'd1);
    checkOutput("range_idvalid", 64'(outIdValid), 64'd1);
    checkOutput("range_erronehot", 64'(errOnehot), 64'd0);
    checkOutput("range_lock", 64'(lock), 64'h00008);
    checkOutput("range_map3", 64'(mapLane(3)), 64'd10);
    checkOutput("range_map5", 64'(mapLane(5)), 64'd8);
    applyStimulus(1'b0, 5'd0, 20'h00000, 1'b0);
    checkOutput("range_strobe_drop", 64'(errRange), 64'd0);

    $display("[TB] clear with valid");
    applyStimulus(1'b1, 5'd3, 20'h00400, 1'b1);
    checkOutput("clrv_idvalid", 64'(outIdValid), 64'd1);
    checkOutput("clrv_id", 64'(outId), 64'd10);
    checkOutput("clrv_lock", 64'(lock), 64'd0);
    checkOutput("clrv_map3", 64'(mapLane(3)), 64'd10);

    $display("[TB] full permutation lock");
    for (int rep = 0; rep < 4; rep++) begin
      for (int p = 0; p < NB_LANES; p++) begin
        permId = 20'h00001 << (19 - p);
        applyStimulus(1'b1, NB_LANE_ID'(p), permId, 1'b0);
      end
    end
    checkOutput("perm_lock", 64'(lock), 64'hFFFFF);
    checkOutput("perm_alllocked_early", 64'(allLocked), 64'd0);
    checkOutput("perm_map0", 64'(mapLane(0)), 64'd19);
    checkOutput("perm_map19", 64'(mapLane(19)), 64'd0);
    applyStimulus(1'b0, 5'd0, 20'h00000, 1'b0);
    checkOutput("perm_alllocked", 64'(allLocked), 64'd1);
    checkOutput("perm_dup", 64'(dupErr), 64'd0);

    $display("[TB] clear after lock");
    applyStimulus(1'b0, 5'd0, 20'h00000, 1'b1);
    checkOutput("clr_lock", 64'(lock), 64'd0);
    checkOutput("clr_alllocked_lag", 64'(allLocked), 64'd1);
    checkOutput("clr_map0_kept", 64'(mapLane(0)), 64'd19);
    applyStimulus(1'b0, 5'd0, 20'h00000, 1'b0);
    checkOutput("clr_alllocked", 64'(allLocked), 64'd0);

    $display("[TB] duplicate ids");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, 5'd0, 20'h00004, 1'b0);
      applyStimulus(1'b1, 5'd1, 20'h00004, 1'b0);
    end
    checkOutput("dup_lock", 64'(lock), 64'h00003);
    checkOutput("dup_early", 64'(dupErr), 64'd0);
    applyStimulus(1'b0, 5'd0, 20'h00000, 1'b0);
    checkOutput("dup_err", 64'(dupErr), 64'(EXP_DUP));

    $display("[TB] reset mid-lock");
    resetN = 1'b0;
    #1;
    checkOutput("midrst_lock", 64'(lock), 64'd0);
    checkOutput("midrst_map", 64'(|map), 64'd0);
    checkOutput("midrst_dup", 64'(dupErr), 64'd0);
    checkOutput("midrst_id", 64'(outId), 64'd0);
    checkOutput("midrst_alllocked", 64'(allLocked), 64'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;

    $display("[TB] lock after reset");
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(1'b1, 5'd2, 20'h00001, 1'b0);
      if (n == 3) checkOutput("postrst_lock_n3", 64'(lock), 64'd0);
    end
    checkOutput("postrst_lock_n4", 64'(lock), 64'h00004);
    checkOutput("postrst_map2", 64'(mapLane(2)), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
